// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory front end.
// Access-size encodings and controller state.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        IDLE,
        RMW
    } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane datapath for the data memory.
// Byte enables, store merge, load extract/extend.
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsgn,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rd,
    output logic [7:0]  be,
    output logic [63:0] merged,
    output logic [63:0] ld_data
);

    logic [63:0] wsh;
    logic [63:0] rsh;

    assign wsh = wdata << {off, 3'b000};
    assign rsh = rd >> {off, 3'b000};

    // byte enables for the addressed lanes
    always_comb begin
        be = 8'h00;
        unique case (size)
            SZ_B: be = 8'h01 << off;
            SZ_H: be = 8'h03 << off;
            SZ_W: be = 8'h0f << off;
            SZ_D: be = 8'hff;
            default: be = 8'h00;
        endcase
    end

    // replace enabled lanes of the old word with store data
    always_comb begin
        merged = rd;
        for (int i = 0; i < 8; i++) begin
            if (be[i])
                merged[i*8 +: 8] = wsh[i*8 +: 8];
        end
    end

    // right-align and extend load data
    always_comb begin
        ld_data = rsh;
        unique case (size)
            SZ_B: ld_data = unsgn ? {56'd0, rsh[7:0]}
                                  : {{56{rsh[7]}}, rsh[7:0]};
            SZ_H: ld_data = unsgn ? {48'd0, rsh[15:0]}
                                  : {{48{rsh[15]}}, rsh[15:0]};
            SZ_W: ld_data = unsgn ? {32'd0, rsh[31:0]}
                                  : {{32{rsh[31]}}, rsh[31:0]};
            SZ_D: ld_data = rsh;
            default: ld_data = rsh;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory front end: CPU/loader arbitration,
// sub-word stores via read-modify-write.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int IDX_W        = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_misalign,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_we,
    input  logic [63:0] ld_addr,
    input  logic [63:0] ld_wdata,
    output logic        ld_rvalid,
    output logic [63:0] ld_rdata,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wd,
    input  logic [63:0] mem_rd
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    starve_cnt;
    logic [IDX_W-1:0] rmw_idx;
    logic [63:0]      rmw_word;

    logic        misal;
    logic        cpu_ok;
    logic        forced;
    logic        ld_grant;
    logic        cpu_go;
    logic        subword;
    logic        rmw_load;
    logic [7:0]  be;
    logic [63:0] merged;
    logic [63:0] ld_data;
    logic        unused_ld_lsb;

    assign unused_ld_lsb = ^{ld_addr[2:0], be};

    dmem_lane u_lane (
        .size    (cpu_size),
        .unsgn   (cpu_unsigned),
        .off     (cpu_addr[2:0]),
        .wdata   (cpu_wdata),
        .rd      (mem_rd),
        .be      (be),
        .merged  (merged),
        .ld_data (ld_data)
    );

    // alignment check of the CPU address against access size
    always_comb begin
        misal = 1'b0;
        unique case (cpu_size)
            SZ_B: misal = 1'b0;
            SZ_H: misal = cpu_addr[0];
            SZ_W: misal = |cpu_addr[1:0];
            SZ_D: misal = |cpu_addr[2:0];
            default: misal = 1'b0;
        endcase
    end

    assign cpu_misalign = rst_n & cpu_req & misal;
    assign cpu_ok       = rst_n & cpu_req & ~misal;
    assign forced       = (starve_cnt == LIMIT);
    assign ld_grant     = rst_n & (state == IDLE) & ld_valid
                        & (~cpu_ok | forced);
    assign cpu_go       = cpu_ok & (state == IDLE) & ~ld_grant;
    assign subword      = cpu_we & (cpu_size != SZ_D);

    // port steering, handshakes and next state
    always_comb begin
        state_nx  = state;
        cpu_rdata = 64'd0;
        cpu_stall = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {cpu_addr[63:3], 3'b000};
        mem_wd    = cpu_wdata;
        rmw_load  = 1'b0;
        unique case (1'b1)
            (state == RMW): begin
                mem_we   = rst_n;
                mem_addr = {{(61-IDX_W){1'b0}}, rmw_idx, 3'b000};
                mem_wd   = rmw_word;
                state_nx = IDLE;
            end
            ld_grant: begin
                ld_ready  = 1'b1;
                mem_addr  = {ld_addr[63:3], 3'b000};
                mem_we    = ld_we;
                mem_wd    = ld_wdata;
                cpu_stall = cpu_ok;
            end
            cpu_go: begin
                if (!cpu_we) begin
                    cpu_rdata = ld_data;
                end else if (!subword) begin
                    mem_we = 1'b1;
                end else begin
                    cpu_stall = 1'b1;
                    rmw_load  = 1'b1;
                    state_nx  = RMW;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // loader starvation counter, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!ld_valid || ld_grant)
            starve_cnt <= '0;
        else if (!forced)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // capture merged word and index for the write-back cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmw_idx  <= '0;
            rmw_word <= '0;
        end else if (rmw_load) begin
            rmw_idx  <= cpu_addr[IDX_W+2:3];
            rmw_word <= merged;
        end
    end

    // loader read return, one cycle after grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            ld_rvalid <= ld_grant & ~ld_we;
            if (ld_grant && !ld_we)
                ld_rdata <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a
// behavioural 1024 x 64 memory.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_misalign;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_we;
    logic [63:0] ld_addr;
    logic [63:0] ld_wdata;
    logic        ld_rvalid;
    logic [63:0] ld_rdata;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wd;
    logic [63:0] mem_rd;

    logic [63:0] mem [0:1023];

    int nchk;
    int nerr;
    int refused;
    bit granted;

    dmem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_misalign (cpu_misalign),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_rvalid    (ld_rvalid),
        .ld_rdata     (ld_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[12:3]];

    // memory array: synchronous write
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr[12:3]] <= mem_wd;
    end

    task automatic chk(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic cpu_set(input logic req, input logic we,
                           input logic [1:0] sz, input logic u,
                           input logic [63:0] a,
                           input logic [63:0] wd);
        cpu_req      = req;
        cpu_we       = we;
        cpu_size     = sz;
        cpu_unsigned = u;
        cpu_addr     = a;
        cpu_wdata    = wd;
    endtask

    task automatic ld_set(input logic v, input logic we,
                          input logic [63:0] a,
                          input logic [63:0] wd);
        ld_valid = v;
        ld_we    = we;
        ld_addr  = a;
        ld_wdata = wd;
    endtask

    initial begin
        nchk  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        cpu_set(0, 0, SZ_B, 0, 64'd0, 64'd0);
        ld_set(0, 0, 64'd0, 64'd0);

        // reset state
        #12;
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_ready", 64'(ld_ready), 64'd0);
        chk("rst_rvalid", 64'(ld_rvalid), 64'd0);
        chk("rst_rdata", ld_rdata, 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // preload word 0 through the loader
        @(negedge clk);
        ld_set(1, 1, 64'h0, 64'h8877665544332211);
        #1;
        chk("pre_ready", 64'(ld_ready), 64'd1);
        chk("pre_we", 64'(mem_we), 64'd1);
        @(negedge clk);
        ld_set(0, 0, 64'd0, 64'd0);

        // loads from word 0
        cpu_set(1, 0, SZ_B, 0, 64'h7, 64'd0);
        #1;
        chk("lb7", cpu_rdata, 64'hFFFFFFFFFFFFFF88);
        chk("lb7_stall", 64'(cpu_stall), 64'd0);
        @(negedge clk);
        cpu_set(1, 0, SZ_B, 1, 64'h7, 64'd0);
        #1;
        chk("lbu7", cpu_rdata, 64'h88);
        chk("lbu7_stall", 64'(cpu_stall), 64'd0);
        @(negedge clk);
        cpu_set(1, 0, SZ_W, 0, 64'h4, 64'd0);
        #1;
        chk("lw4", cpu_rdata, 64'hFFFFFFFF88776655);
        chk("lw4_stall", 64'(cpu_stall), 64'd0);
        @(negedge clk);
        cpu_set(1, 0, SZ_H, 1, 64'h6, 64'd0);
        #1;
        chk("lhu6", cpu_rdata, 64'h8877);
        @(negedge clk);
        cpu_set(1, 0, SZ_H, 0, 64'h2, 64'd0);
        #1;
        chk("lh2", cpu_rdata, 64'h0000000000004433);

        // SH 0xBEEF at 0x2: one stall then write-back
        @(negedge clk);
        cpu_set(1, 1, SZ_H, 0, 64'h2, 64'hBEEF);
        #1;
        chk("sh_stall1", 64'(cpu_stall), 64'd1);
        chk("sh_we1", 64'(mem_we), 64'd0);
        @(negedge clk);
        #1;
        chk("sh_stall2", 64'(cpu_stall), 64'd0);
        chk("sh_we2", 64'(mem_we), 64'd1);
        chk("sh_wd", mem_wd, 64'h88776655BEEF2211);
        @(negedge clk);
        cpu_set(1, 0, SZ_D, 0, 64'h0, 64'd0);
        #1;
        chk("sh_mem", mem[0], 64'h88776655BEEF2211);
        chk("ld0", cpu_rdata, 64'h88776655BEEF2211);

        // misaligned SD
        @(negedge clk);
        cpu_set(1, 1, SZ_D, 0, 64'h4, 64'h1122334455667788);
        #1;
        chk("mis_flag", 64'(cpu_misalign), 64'd1);
        chk("mis_stall", 64'(cpu_stall), 64'd0);
        chk("mis_we", 64'(mem_we), 64'd0);
        chk("mis_rdata", cpu_rdata, 64'd0);
        @(negedge clk);
        cpu_set(0, 0, SZ_B, 0, 64'd0, 64'd0);
        #1;
        chk("mis_mem", mem[0], 64'h88776655BEEF2211);

        // loader write then read of 0x40
        @(negedge clk);
        ld_set(1, 1, 64'h40, 64'hDEADBEEF);
        #1;
        chk("lw_ready", 64'(ld_ready), 64'd1);
        @(negedge clk);
        ld_set(1, 0, 64'h40, 64'd0);
        #1;
        chk("lr_ready", 64'(ld_ready), 64'd1);
        chk("lr_rv0", 64'(ld_rvalid), 64'd0);
        @(negedge clk);
        ld_set(0, 0, 64'd0, 64'd0);
        #1;
        chk("lr_rvalid", 64'(ld_rvalid), 64'd1);
        chk("lr_rdata", ld_rdata, 64'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("lr_pulse", 64'(ld_rvalid), 64'd0);

        // starvation: CPU loads every cycle, loader waits
        @(negedge clk);
        cpu_set(1, 0, SZ_D, 0, 64'h0, 64'd0);
        ld_set(1, 0, 64'h40, 64'd0);
        refused = 0;
        granted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ld_ready) begin
                granted = 1'b1;
                chk("force_stall", 64'(cpu_stall), 64'd1);
                break;
            end
            refused++;
            chk("refuse_stall", 64'(cpu_stall), 64'd0);
            @(negedge clk);
        end
        chk("force_grant", 64'(granted), 64'd1);
        chk("refused", 64'(refused), 64'd8);
        @(posedge clk);
        #1;
        chk("starve_clr", 64'(dut.starve_cnt), 64'd0);
        chk("force_rvalid", 64'(ld_rvalid), 64'd1);
        chk("force_rdata", ld_rdata, 64'hDEADBEEF);
        chk("force_state", 64'(dut.state), 64'(IDLE));
        @(negedge clk);
        #1;
        chk("after_ready", 64'(ld_ready), 64'd0);
        chk("after_stall", 64'(cpu_stall), 64'd0);
        chk("after_rdata", cpu_rdata, 64'h88776655BEEF2211);

        // reset asserted during RMW
        @(negedge clk);
        ld_set(0, 0, 64'd0, 64'd0);
        cpu_set(1, 1, SZ_B, 0, 64'h41, 64'h55);
        #1;
        chk("rr_stall", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        #1;
        chk("rr_we_rmw", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_we_rst", 64'(mem_we), 64'd0);
        chk("rr_state", 64'(dut.state), 64'(IDLE));
        chk("rr_rvalid", 64'(ld_rvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("rr_mem", mem[8], 64'hDEADBEEF);
        @(negedge clk);
        cpu_set(0, 0, SZ_B, 0, 64'd0, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1);
    end

endmodule
